// File: rtl/oram_pkg.sv
// rtl/oram_pkg.sv - Path-ORAM sizing, tuple/bucket types, FSM states and tree addressing.
package oram_pkg;
  localparam int A     = 8;
  localparam int D     = 6;
  localparam int K     = 3;
  localparam int LW    = D - 1;
  localparam int VW    = 8 * A;
  localparam int T     = LW + D + VW + 1;
  localparam int NODES = (1 << D) - 1;

  typedef logic [LW-1:0]        leaf_t;
  typedef logic [D-1:0]         blk_t;
  typedef logic [$clog2(D)-1:0] lvl_t;

  typedef struct packed {
    leaf_t          pos;
    blk_t           b;
    logic [VW-1:0]  val;
    logic           empty_n;
  } memory_tuple;

  typedef memory_tuple [K-1:0] memory_bucket;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_READ, ST_SCAN, ST_WRITE, ST_RESP
  } state_t;

  // Node on the root-to-leaf path at the given level (root = 0, children 2i+1 / 2i+2).
  function automatic blk_t node_index(input lvl_t level, input leaf_t leaf);
    blk_t w_base;
    blk_t w_off;
    w_base = D'((1 << level) - 1);
    w_off  = D'(leaf >> (LW - int'(level)));
    return w_base + w_off;
  endfunction
endpackage

// File: rtl/oram_if.sv
// rtl/oram_if.sv - request/response and bucket-RAM signals of the ORAM path controller.
interface oram_if;
  import oram_pkg::*;

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  blk_t          req_block;
  logic [VW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_hit;
  logic [VW-1:0] rsp_rdata;
  logic          err_overflow;
  blk_t          mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  memory_bucket  mem_wdata;
  memory_bucket  mem_rdata;

  modport master (
    input  req_valid, req_write, req_block, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_hit, rsp_rdata, err_overflow,
           mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport slave (
    output req_valid, req_write, req_block, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_hit, rsp_rdata, err_overflow,
           mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/oram_lfsr.sv
// rtl/oram_lfsr.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running leaf source.
module oram_lfsr
  import oram_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  output leaf_t o_leaf
);
  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign o_leaf = r_lfsr[LW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= 16'hACE1;
    else        r_lfsr <= {r_lfsr[14:0], w_fb};
  end
endmodule

// File: rtl/oram_path_ctrl.sv
// rtl/oram_path_ctrl.sv - Path-ORAM access sequencer: read path, extract/remap block,
// write path back leaf-to-root with the block placed as deep as both paths allow.
module oram_path_ctrl
  import oram_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  oram_if.master bus
);
  state_t        r_state, w_next;
  lvl_t          r_lvl, r_tgt, w_cap_lvl, w_lcp, w_tgt;
  blk_t          r_cnt, r_blk;
  logic          r_write, r_found, r_ins, r_err;
  logic [VW-1:0] r_wdata, r_val, w_inc_val;
  leaf_t         r_old, r_new, w_leaf;
  leaf_t         r_pos [2**D];
  memory_bucket  r_buf [D];
  memory_bucket  w_clean, w_wbucket;
  logic          w_capture, w_inc_hit, w_any, w_hold;

  oram_lfsr u_lfsr (.clk(clk), .rst_n(rst_n), .o_leaf(w_leaf));

  function automatic logic bucket_free(input memory_bucket bk);
    logic f;
    f = 1'b0;
    for (int s = 0; s < K; s++) if (!bk[s].empty_n) f = 1'b1;
    return f;
  endfunction

  function automatic memory_bucket bucket_insert(input memory_bucket bk, input memory_tuple t);
    memory_bucket o;
    logic         placed;
    o      = bk;
    placed = 1'b0;
    for (int s = 0; s < K; s++) begin
      if (!placed && !o[s].empty_n) begin
        o[s]   = t;
        placed = 1'b1;
      end
    end
    return o;
  endfunction

  // Read data lags mem_rd by one cycle, so the bucket arriving now belongs to the previous level.
  assign w_capture = ((r_state == ST_READ) && (r_lvl != '0)) || (r_state == ST_SCAN);
  assign w_cap_lvl = (r_state == ST_SCAN) ? lvl_t'(D - 1) : r_lvl - 1'b1;
  assign w_hold    = r_write | r_found | w_inc_hit;

  always_comb begin
    w_clean   = bus.mem_rdata;
    w_inc_hit = 1'b0;
    w_inc_val = '0;
    for (int s = K - 1; s >= 0; s--) begin
      if (bus.mem_rdata[s].empty_n && (bus.mem_rdata[s].b == r_blk)) begin
        w_clean[s].empty_n = 1'b0;
        w_inc_hit          = 1'b1;
        w_inc_val          = bus.mem_rdata[s].val;
      end
    end
  end

  // Deepest level shared by old and new paths that still has a free slot after removal.
  always_comb begin
    w_lcp = '0;
    w_tgt = '0;
    w_any = 1'b0;
    for (int l = 0; l < D; l++)
      if ((r_old >> (LW - l)) == (r_new >> (LW - l))) w_lcp = lvl_t'(l);
    for (int l = 0; l < D; l++) begin
      if ((lvl_t'(l) <= w_lcp) &&
          ((l == D - 1) ? bucket_free(w_clean) : bucket_free(r_buf[l]))) begin
        w_tgt = lvl_t'(l);
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_wbucket = r_buf[r_lvl];
    if (r_ins && (r_lvl == r_tgt))
      w_wbucket = bucket_insert(r_buf[r_lvl],
                    '{pos: r_new, b: r_blk, val: (r_write ? r_wdata : r_val), empty_n: 1'b1});
  end

  always_comb begin
    w_next        = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (r_state)
      ST_INIT: begin
        if (r_cnt != '0) begin
          bus.mem_wr   = 1'b1;
          bus.mem_addr = r_cnt - 1'b1;
        end
        if (r_cnt == blk_t'(NODES)) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_next = ST_READ;
      end
      ST_READ: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = node_index(r_lvl, r_old);
        if (r_lvl == lvl_t'(D - 1)) w_next = ST_SCAN;
      end
      ST_SCAN:  w_next = ST_WRITE;
      ST_WRITE: begin
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = node_index(r_lvl, r_old);
        bus.mem_wdata = w_wbucket;
        if (r_lvl == '0) w_next = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        w_next        = ST_IDLE;
      end
      default: w_next = ST_INIT;
    endcase
  end

  assign bus.rsp_hit      = (r_state == ST_RESP) && (r_found || r_write);
  assign bus.rsp_rdata    = ((r_state == ST_RESP) && r_found) ? r_val : '0;
  assign bus.err_overflow = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_lvl   <= '0;
      r_tgt   <= '0;
      r_blk   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_old   <= '0;
      r_new   <= '0;
      r_found <= 1'b0;
      r_val   <= '0;
      r_ins   <= 1'b0;
      r_err   <= 1'b0;
      for (int b = 0; b < 2**D; b++) r_pos[b] <= leaf_t'(b);
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_INIT: r_cnt <= r_cnt + 1'b1;
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_blk              <= bus.req_block;
            r_write            <= bus.req_write;
            r_wdata            <= bus.req_wdata;
            r_old              <= r_pos[bus.req_block];
            r_new              <= w_leaf;
            r_pos[bus.req_block] <= w_leaf;
            r_lvl              <= '0;
            r_found            <= 1'b0;
            r_val              <= '0;
          end
        end
        ST_READ:  r_lvl <= r_lvl + 1'b1;
        ST_SCAN: begin
          r_lvl <= lvl_t'(D - 1);
          r_tgt <= w_tgt;
          r_ins <= w_hold && w_any;
          if (w_hold && !w_any) r_err <= 1'b1;
        end
        ST_WRITE: r_lvl <= r_lvl - 1'b1;
        default: ;
      endcase
      if (w_capture && w_inc_hit && !r_found) begin
        r_found <= 1'b1;
        r_val   <= w_inc_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) r_buf[w_cap_lvl] <= w_clean;
  end
endmodule

// File: tb/tb_oram_path_ctrl.sv
// tb/tb_oram_path_ctrl.sv - randomized self-checking bench with a Path-ORAM reference model,
// a bucket RAM, and directed INIT / miss / overwrite / overflow / mid-access reset cases.
module tb_oram_path_ctrl;
  import oram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oram_if bus();
  oram_path_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  memory_bucket ram [NODES];
  logic         poke_en = 1'b0;
  blk_t         poke_addr = '0;
  memory_bucket poke_data = '0;

  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];
    if (poke_en) ram[poke_addr] <= poke_data;
  end

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  memory_bucket  m_tree [NODES];
  logic [4:0]    m_pos  [64];
  bit            m_err;
  logic [63:0]   d_val  [64];
  bit            d_has  [64];
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int mnode(input int l, input int leaf);
    return (2 ** l) - 1 + (leaf >> (D - 1 - l));
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NODES; n++) m_tree[n] = '0;
    for (int b = 0; b < 64; b++) begin
      m_pos[b] = 5'(b);
      d_has[b] = 1'b0;
      d_val[b] = '0;
    end
    m_err = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_hit"}, bus.rsp_hit, 0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_err"}, bus.err_overflow, 0);
    chk({tag, "_mem_rd"}, bus.mem_rd, 0);
    chk({tag, "_mem_wr"}, bus.mem_wr, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  task automatic init_sweep();
    int nwr = 0;
    int guard = 0;
    while (!bus.req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
      chk("init_no_rd", bus.mem_rd, 0);
      if (bus.mem_wr) begin
        chk("init_addr", bus.mem_addr, nwr);
        chk("init_wdata", bus.mem_wdata, 0);
        nwr++;
      end
    end
    chk("init_count", nwr, 63);
    chk("init_ready", bus.req_ready, 1);
  endtask

  task automatic access(input bit wr, input logic [5:0] blk, input logic [63:0] wd,
                        input bit want_split, input int abort_at,
                        output bit o_hit, output logic [63:0] o_rd, output int o_rsp_cyc);
    int           guard, lcp, lv;
    logic [4:0]   old, nl;
    bit           found, placed, hold, e_hit, e_mrd, e_mwr;
    logic [63:0]  fval, e_rd;
    memory_tuple  t;
    memory_bucket exp_wb [D];
    o_hit = 1'b0;
    o_rd = '0;
    o_rsp_cyc = -1;
    @(negedge clk);
    guard = 0;
    while ((!bus.req_ready || (want_split && (m_lfsr[4] == m_pos[blk][4]))) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      chk("accept_wait", guard, 0);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_block = blk;
    bus.req_wdata = wd;
    old = m_pos[blk];
    nl = m_lfsr[4:0];
    m_pos[blk] = nl;
    found = 1'b0;
    fval = '0;
    for (int l = 0; l < D; l++)
      for (int s = 0; s < K; s++)
        if (m_tree[mnode(l, old)][s].empty_n && m_tree[mnode(l, old)][s].b == blk) begin
          if (!found) begin
            found = 1'b1;
            fval = m_tree[mnode(l, old)][s].val;
          end
          m_tree[mnode(l, old)][s].empty_n = 1'b0;
        end
    hold = wr || found;
    lcp = 0;
    for (int l = 0; l < D; l++)
      if ((old >> (D - 1 - l)) == (nl >> (D - 1 - l))) lcp = l;
    if (hold) begin
      placed = 1'b0;
      t.pos = nl;
      t.b = blk;
      t.val = wr ? wd : fval;
      t.empty_n = 1'b1;
      for (int l = lcp; l >= 0; l--)
        for (int s = 0; s < K; s++)
          if (!placed && !m_tree[mnode(l, old)][s].empty_n) begin
            m_tree[mnode(l, old)][s] = t;
            placed = 1'b1;
          end
      if (!placed) m_err = 1'b1;
    end
    for (int l = 0; l < D; l++) exp_wb[l] = m_tree[mnode(l, old)];
    e_hit = found || wr;
    e_rd = found ? fval : 64'd0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 2 * D + 3; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        model_reset();
        return;
      end
      e_mrd = (c >= 1) && (c <= D);
      e_mwr = (c >= D + 2) && (c <= 2 * D + 1);
      chk("mem_rd", bus.mem_rd, e_mrd);
      chk("mem_wr", bus.mem_wr, e_mwr);
      if (e_mrd) chk("rd_addr", bus.mem_addr, mnode(c - 1, old));
      if (e_mwr) begin
        lv = 2 * D + 1 - c;
        chk("wr_addr", bus.mem_addr, mnode(lv, old));
        chk("wr_bucket", bus.mem_wdata, exp_wb[lv]);
      end else begin
        chk("wdata_idle", bus.mem_wdata, 0);
      end
      chk("rsp_valid", bus.rsp_valid, c == 2 * D + 2);
      chk("req_ready", bus.req_ready, c == 2 * D + 3);
      if (bus.rsp_valid) begin
        o_rsp_cyc = c;
        o_hit = bus.rsp_hit;
        o_rd = bus.rsp_rdata;
      end
      if (c == 2 * D + 2) begin
        chk("rsp_hit", bus.rsp_hit, e_hit);
        chk("rsp_rdata", bus.rsp_rdata, e_rd);
        chk("err_overflow", bus.err_overflow, m_err);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit           h;
    logic [63:0]  rd, wd;
    int           cyc, cnt9;
    logic [5:0]   blk;
    bit           wr;
    memory_tuple  t;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_block = '0;
    bus.req_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    init_sweep();

    access(1'b0, 6'd5, 64'd0, 1'b0, 0, h, rd, cyc);
    chk("miss5_hit", h, 0);
    chk("miss5_rdata", rd, 0);
    chk("miss5_rsp_cycle", cyc, 14);

    access(1'b1, 6'd5, 64'h0123_4567_89AB_CDEF, 1'b0, 0, h, rd, cyc);
    chk("wr5_hit", h, 1);
    access(1'b0, 6'd5, 64'd0, 1'b0, 0, h, rd, cyc);
    chk("rd5_hit", h, 1);
    chk("rd5_rdata", rd, 64'h0123_4567_89AB_CDEF);

    access(1'b1, 6'd9, 64'd1, 1'b0, 0, h, rd, cyc);
    access(1'b1, 6'd9, 64'd2, 1'b0, 0, h, rd, cyc);
    chk("wr9_second_old", rd, 64'd1);
    access(1'b0, 6'd9, 64'd0, 1'b0, 0, h, rd, cyc);
    chk("rd9_rdata", rd, 64'd2);
    cnt9 = 0;
    for (int n = 0; n < NODES; n++)
      for (int s = 0; s < K; s++)
        if (ram[n][s].empty_n && ram[n][s].b == 6'd9) cnt9++;
    chk("ram_one_tuple9", cnt9, 1);

    d_has[5] = 1'b1; d_val[5] = 64'h0123_4567_89AB_CDEF;
    d_has[9] = 1'b1; d_val[9] = 64'd2;
    for (int i = 0; i < 40; i++) begin
      blk = 6'($urandom_range(0, 15));
      wr = 1'($urandom);
      wd = {$urandom, $urandom};
      access(wr, blk, wd, 1'b0, 0, h, rd, cyc);
      if (!m_err) begin
        chk("dict_hit", h, wr || d_has[blk]);
        chk("dict_rdata", rd, d_has[blk] ? d_val[blk] : 64'd0);
      end
      if (wr) begin
        d_has[blk] = 1'b1;
        d_val[blk] = wd;
      end
    end

    access(1'b1, 6'd5, 64'hDEAD_BEEF_0000_0005, 1'b0, 0, h, rd, cyc);
    access(1'b0, 6'd5, 64'd0, 1'b0, 5, h, rd, cyc);
    repeat (2) @(negedge clk);
    check_reset_vals("held");
    rst_n = 1'b1;
    init_sweep();
    access(1'b0, 6'd5, 64'd0, 1'b0, 0, h, rd, cyc);
    chk("post_reset_hit", h, 0);
    chk("post_reset_rdata", rd, 0);

    @(negedge clk);
    for (int s = 0; s < K; s++) begin
      t.pos = 5'(s * 7);
      t.b = 6'(50 + s);
      t.val = 64'(100 + s);
      t.empty_n = 1'b1;
      poke_data[s] = t;
    end
    poke_addr = '0;
    poke_en = 1'b1;
    m_tree[0] = poke_data;
    @(negedge clk);
    poke_en = 1'b0;
    access(1'b1, 6'd40, 64'h4040, 1'b1, 0, h, rd, cyc);
    chk("ovf_set", bus.err_overflow, 1);
    access(1'b0, 6'd40, 64'd0, 1'b0, 0, h, rd, cyc);
    chk("ovf_block_lost", h, 0);
    access(1'b0, 6'd51, 64'd0, 1'b0, 0, h, rd, cyc);
    chk("root_block51", rd, 64'd101);
    access(1'b1, 6'd3, 64'h33, 1'b0, 0, h, rd, cyc);
    chk("ovf_sticky", bus.err_overflow, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/oram_path_ctrl.md
# oram_path_ctrl

Access sequencer for the Path-ORAM binary tree. Accepts one block read/write request at a time and looks up the block's leaf in an internal position map. It streams every bucket on the root-to-leaf path out of an external bucket RAM, extracts or replaces the block, and remaps the block to a fresh pseudo-random leaf. It then writes the path back leaf-to-root, re-placing the block as deep as the old and new paths allow.

## Interface
- A, 8: bytes per block
- D, 6: tree depth in levels; block number is D bits, leaf index D-1 bits, nodes 2^D-1 = 63
- K, 3: tuples per bucket
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  controller idle, can accept
- req_write  in  1  1 = write req_wdata, 0 = read
- req_block  in  D  block number
- req_wdata  in  8A  write data
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_hit  out  1  block was found in tree (always 1 for writes)
- rsp_rdata  out  8A  block value before access; 0 on miss
- err_overflow  out  1  sticky: re-placement failed, block lost
- mem_addr  out  D  node index; root 0, children 2i+1 / 2i+2
- mem_rd  out  1  read strobe; mem_rdata valid next cycle
- mem_wr  out  1  write strobe
- mem_wdata  out  K*T  bucket, T = (D-1)+D+8A+1 = 76 bits per tuple {pos, b, val, empty_n}, slot 0 in LSBs
- mem_rdata  in  K*T  bucket read data

## Operation
- States: INIT, IDLE, READ, SCAN, WRITE, RESP.
- INIT (after reset): writes an all-zero bucket to nodes 0..2^D-2 in order, one per cycle, then enters IDLE; req_ready=0 throughout.
- Position map: 2^D x (D-1) flops; reset value pos_map[b] = b[D-2:0].
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, steps every cycle from reset release. Leaf value new_leaf = lfsr[D-2:0], captured at accept.
- Accept (req_valid & req_ready in IDLE): latch request and old_leaf = pos_map[req_block]; pos_map[req_block] <= new_leaf.
- Path node at level l: (2^l - 1) + (leaf >> (D-1-l)).
- READ: issue mem_rd for levels 0..D-1 of old_leaf path. Each returned bucket is stored in the path buffer (D buckets). In the same cycle, scan the bucket for tuples with empty_n=1 and b=req_block.
- Match: the first hit (lowest level, then lowest slot) supplies rsp_rdata. All matching tuples get empty_n cleared in the buffer.
- Held block: write → req_wdata; read hit → found value; read miss → none, and nothing is inserted.
- Target level: the deepest level l ≤ lcp, where lcp is the deepest level with old_leaf>>(D-1-l) == new_leaf>>(D-1-l). The chosen level must have a free slot after match removal. The block goes in the lowest free slot with pos=new_leaf, b=req_block, empty_n=1.
- If no level 0..lcp has a free slot: block dropped, err_overflow set (cleared only by reset), access otherwise completes normally.
- WRITE: mem_wr of buffered buckets for levels D-1 down to 0, same old_leaf path.
- RESP: rsp_valid=1 with rsp_hit, rsp_rdata; next state IDLE.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_hit=0, rsp_rdata=0, err_overflow=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Reset asserted mid-access aborts immediately, FSM to INIT; position map and tree are fully reinitialised.
- Cycle 0 is the accept cycle.
- Cycles 1..D: mem_rd, levels 0..D-1.
- Cycle D+1 (SCAN): last bucket captured, target level computed.
- Cycles D+2..2D+1: mem_wr, levels D-1..0.
- Cycle 2D+2: rsp_valid (14 for D=6).
- Cycle 2D+3: IDLE with req_ready=1; earliest next accept.
- mem_rd and mem_wr are never asserted together. mem_wdata is don't-care-zero when mem_wr=0.

## Structure
- oram_pkg: A, D, K, T; packed typedefs memory_tuple and memory_bucket; function node_index(level, leaf).
- Sub-module oram_lfsr: 16-bit LFSR, same reset, advances every cycle.

## Test plan
- Reset, then count mem_wr pulses in INIT → exactly 63 writes, addresses 0..62, then req_ready=1.
- Read block 5 with no prior write → rsp_hit=0, rsp_rdata=0, rsp_valid at cycle 14, no insertion (written buckets equal read buckets).
- Write block 5 = 64'h0123_4567_89AB_CDEF, then read block 5 → rsp_hit=1, rsp_rdata=64'h0123_4567_89AB_CDEF. The second access reads along the leaf chosen by the first.
- Write block 9 twice (values 1, then 2), then read → rsp_rdata=2. A scoreboard of the bucket RAM shows exactly one tuple with b=9.
- Fill root so that all K slots hold other blocks, then force lcp=0 (old/new leaf MSB differ) with a write → err_overflow=1 and stays 1 after later accesses.
- Assert rst_n=0 at cycle 5 of an access → all outputs at reset values immediately. After release, a full INIT sweep runs, and a read of the earlier-written block misses.
